tt_sweep_checker: RTL and testbench

//  Parametrised, self-checking exhaustive sweep for an N-input, 1-output

---
 rtl/tt_sweep_if.sv | 28 ++
 rtl/tt_sweep_checker.sv | 108 ++++++++++
 tb/tb_tt_sweep_checker.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/tt_sweep_if.sv
// Bus between the sweep checker and the stimulus/DUT side.
// The checker takes the master view; the bench or lab harness takes the slave view.
interface tt_sweep_if #(
   parameter int N_IN = 3
);
   logic            start;
   logic [N_IN-1:0] stim;
   logic            dut_out;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_IN:0]   err_cnt;
   logic            mismatch;
   logic            first_err_vld;
   logic [N_IN-1:0] first_err_vec;

   modport master (
      input  start, dut_out,
      output stim, busy, done, pass, err_cnt,
      output mismatch, first_err_vld, first_err_vec
   );

   modport slave (
      output start, dut_out,
      input  stim, busy, done, pass, err_cnt,
      input  mismatch, first_err_vld, first_err_vec
   );
endinterface

// File: rtl/tt_sweep_checker.sv
// Exhaustive clocked sweep of an N-input combinational block.
// Each vector is compared against a golden truth table after a settle window.
module tt_sweep_checker #(
   parameter int              N_IN   = 3,
   parameter logic [2**N_IN-1:0] TRUTH = 'h40,
   parameter int              SETTLE = 2
) (
   input logic       clk,
   input logic       rst,
   tt_sweep_if.master bus
);
   localparam int CW = $clog2(SETTLE + 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      CHECK,
      DONE
   } state_e;

   state_e          state_q, state_d;
   logic [N_IN-1:0] stim_q, stim_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N_IN:0]   err_q, err_d;
   logic            mis_q, mis_d;
   logic            fvld_q, fvld_d;
   logic [N_IN-1:0] fvec_q, fvec_d;
   logic            bad;

   assign bad = (bus.dut_out != TRUTH[stim_q]);

   always_comb begin
      state_d = state_q;
      stim_d  = stim_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      mis_d   = 1'b0;
      fvld_d  = fvld_q;
      fvec_d  = fvec_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               state_d = WAIT;
               stim_d  = '0;
               cnt_d   = '0;
               err_d   = '0;
               fvld_d  = 1'b0;
               fvec_d  = '0;
            end
         end
         WAIT: begin
            // WAIT spans SETTLE cycles; CHECK adds the final one
            if (cnt_q == CW'(SETTLE - 1)) begin
               state_d = CHECK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         CHECK: begin
            if (bad) begin
               err_d = err_q + (N_IN+1)'(1);
               mis_d = 1'b1;
               if (!fvld_q) begin
                  fvld_d = 1'b1;
                  fvec_d = stim_q;
               end
            end
            if (stim_q == '1) begin
               state_d = DONE;
            end else begin
               state_d = WAIT;
               stim_d  = stim_q + N_IN'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         stim_q  <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         mis_q   <= 1'b0;
         fvld_q  <= 1'b0;
         fvec_q  <= '0;
      end else begin
         state_q <= state_d;
         stim_q  <= stim_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         mis_q   <= mis_d;
         fvld_q  <= fvld_d;
         fvec_q  <= fvec_d;
      end
   end

   assign bus.stim          = stim_q;
   assign bus.busy          = (state_q == WAIT) || (state_q == CHECK);
   assign bus.done          = (state_q == DONE);
   assign bus.pass          = (state_q == DONE) && (err_q == '0);
   assign bus.err_cnt       = err_q;
   assign bus.mismatch      = mis_q;
   assign bus.first_err_vld = fvld_q;
   assign bus.first_err_vec = fvec_q;
endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: default 3-input table plus a
// 4-input AND configuration, with hand-computed expected results.
module tb_tt_sweep_checker;
   logic clk;
   logic rst;
   int   mode;
   int   n_chk;
   int   n_fail;

   tt_sweep_if #(.N_IN(3)) bus ();
   tt_sweep_if #(.N_IN(4)) bus4 ();

   tt_sweep_checker #(
      .N_IN(3), .TRUTH(8'h40), .SETTLE(2)
   ) u_dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   tt_sweep_checker #(
      .N_IN(4), .TRUTH(16'h8000), .SETTLE(1)
   ) u_dut4 (
      .clk(clk), .rst(rst), .bus(bus4)
   );

   // a = stim[2], b = stim[1], c = stim[0]
   always_comb begin
      case (mode)
         1:       bus.dut_out = bus.stim[2] & bus.stim[1];
         2:       bus.dut_out = 1'b1;
         default: bus.dut_out = bus.stim[2] & bus.stim[1] & ~bus.stim[0];
      endcase
   end
   assign bus4.dut_out = &bus4.stim;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Launch (optionally), then count cycles from E0 to done and mismatch pulses.
   task automatic sweep(input bit launch, input bit glitch,
                        output int cyc, output int np);
      bit both;
      cyc  = 0;
      np   = 0;
      both = 1'b0;
      if (launch) begin
         @(negedge clk) bus.start = 1'b1;
         @(negedge clk) bus.start = 1'b0;
      end
      for (int k = 1; k <= 300; k++) begin
         if (glitch && (k == 5 || k == 13)) bus.start = 1'b1;
         else bus.start = 1'b0;
         @(negedge clk);
         if (bus.mismatch) np++;
         if (bus.busy && bus.done) both = 1'b1;
         if (bus.done) begin
            cyc = k;
            break;
         end
      end
      bus.start = 1'b0;
      check("busy_and_done", int'(both), 0);
      if (cyc == 0) check("sweep_timeout", 0, 1);
   endtask

   initial begin
      int cyc;
      int np;
      n_chk     = 0;
      n_fail    = 0;
      mode      = 0;
      bus.start = 1'b0;
      bus4.start = 1'b0;
      rst       = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_stim", int'(bus.stim), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_pass", int'(bus.pass), 0);
      check("rst_err", int'(bus.err_cnt), 0);
      check("rst_fvld", int'(bus.first_err_vld), 0);
      rst = 1'b0;

      // 1: matching DUT
      mode = 0;
      sweep(1'b1, 1'b0, cyc, np);
      check("t1_cycles", cyc, 24);
      check("t1_pass", int'(bus.pass), 1);
      check("t1_err", int'(bus.err_cnt), 0);
      check("t1_fvld", int'(bus.first_err_vld), 0);
      check("t1_pulses", np, 0);
      check("t1_stim_hold", int'(bus.stim), 7);
      check("t1_busy", int'(bus.busy), 0);
      repeat (3) @(negedge clk);
      check("t1_done_held", int'(bus.done), 1);

      // 2: a&b fails only at 7
      mode = 1;
      sweep(1'b1, 1'b0, cyc, np);
      check("t2_cycles", cyc, 24);
      check("t2_err", int'(bus.err_cnt), 1);
      check("t2_fvec", int'(bus.first_err_vec), 7);
      check("t2_fvld", int'(bus.first_err_vld), 1);
      check("t2_pulses", np, 1);
      check("t2_pass", int'(bus.pass), 0);

      // 3: constant 1
      mode = 2;
      sweep(1'b1, 1'b0, cyc, np);
      check("t3_err", int'(bus.err_cnt), 7);
      check("t3_fvec", int'(bus.first_err_vec), 0);
      check("t3_pulses", np, 7);
      check("t3_pass", int'(bus.pass), 0);

      // 4: async reset mid-sweep
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      repeat (9) @(negedge clk);
      check("t4_busy_pre", int'(bus.busy), 1);
      #2 rst = 1'b1;
      #1;
      check("t4_stim", int'(bus.stim), 0);
      check("t4_busy", int'(bus.busy), 0);
      check("t4_err", int'(bus.err_cnt), 0);
      check("t4_fvld", int'(bus.first_err_vld), 0);
      check("t4_fvec", int'(bus.first_err_vec), 0);
      check("t4_mis", int'(bus.mismatch), 0);
      @(negedge clk) rst = 1'b0;
      mode = 0;
      sweep(1'b1, 1'b0, cyc, np);
      check("t4_cycles", cyc, 24);
      check("t4_pass", int'(bus.pass), 1);

      // 5: start pulses while busy are ignored; relaunch from DONE
      mode = 2;
      sweep(1'b1, 1'b1, cyc, np);
      check("t5_cycles", cyc, 24);
      check("t5_err", int'(bus.err_cnt), 7);
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      check("t5_relaunch_err", int'(bus.err_cnt), 0);
      check("t5_relaunch_fvld", int'(bus.first_err_vld), 0);
      check("t5_relaunch_done", int'(bus.done), 0);
      check("t5_relaunch_busy", int'(bus.busy), 1);
      sweep(1'b0, 1'b0, cyc, np);
      check("t5b_cycles", cyc, 24);
      check("t5b_err", int'(bus.err_cnt), 7);
      check("t5b_fvec", int'(bus.first_err_vec), 0);
      check("t5b_pulses", np, 7);

      // 6: 4-input AND, SETTLE=1
      cyc = 0;
      @(negedge clk) bus4.start = 1'b1;
      @(negedge clk) bus4.start = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (bus4.done) begin
            cyc = k;
            break;
         end
      end
      check("t6_cycles", cyc, 32);
      check("t6_pass", int'(bus4.pass), 1);
      check("t6_err", int'(bus4.err_cnt), 0);
      check("t6_stim", int'(bus4.stim), 15);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
